// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM among NUM_REQ renderers,
// with a fixed-latency tagged return path. Optional stall counter: SPRITE_ARB_STATS_EN.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rom_rd,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [DATA_W-1:0]         rdata,
  output logic [NUM_REQ-1:0]        rdata_valid,
  output logic                      busy
`ifdef SPRITE_ARB_STATS_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = ROM_LAT + 1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_nxt;
  logic [PTR_W-1:0]  gnt_idx;
  logic              found;
  logic              gnt_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [DEPTH-1:0]  pv;
  logic [PTR_W-1:0]  pid [DEPTH];
  int                idx;

  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    sel_addr = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt_idx  = PTR_W'(idx);
        sel_addr = req_addr[idx*ADDR_W +: ADDR_W];
      end
    end
    // gnt is held low during reset so no grant can be lost to the async clear
    gnt_any = reset && fetch_en && found;
    gnt     = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
    ptr_nxt = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr         <= '0;
      rom_rd      <= 1'b0;
      rom_addr    <= '0;
      rdata       <= '0;
      rdata_valid <= '0;
      pv          <= '0;
      for (int k = 0; k < DEPTH; k++) pid[k] <= '0;
    end else begin
      if (gnt_any) begin
        ptr      <= ptr_nxt;
        rom_addr <= sel_addr;
      end
      rom_rd <= gnt_any;
      pv     <= {pv[DEPTH-2:0], gnt_any};
      pid[0] <= gnt_idx;
      for (int k = 1; k < DEPTH; k++) pid[k] <= pid[k-1];
      rdata_valid <= '0;
      if (pv[DEPTH-1]) begin
        rdata                     <= rom_data;
        rdata_valid[pid[DEPTH-1]] <= 1'b1;
      end
    end
  end

  assign busy = rom_rd | (|pv);

`ifdef SPRITE_ARB_STATS_EN
  logic [PTR_W-1:0] low_idx;
  logic             stall;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) low_idx = PTR_W'(i);
    end
    stall = (|req) && (!fetch_en || (gnt_idx != low_idx));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: a reference grant model pushes expected
// returns, which are popped and compared when rdata_valid is due.
module tb_sprite_rom_arbiter;

  localparam int NR = 2;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_en;
  logic [NR-1:0] req;
  logic [AW-1:0] addr [NR];
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0] gnt;
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic [DW-1:0] rdata;
  logic [NR-1:0] rdata_valid;
  logic          busy;
`ifdef SPRITE_ARB_STATS_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   stall3;
`endif

  logic [2:0]    req3;
  logic [2:0]    gnt3;
  logic          rom_rd3;
  logic [AW-1:0] rom_addr3;
  logic [DW-1:0] rdata3;
  logic [2:0]    rdata_valid3;
  logic          busy3;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign req_addr = {addr[1], addr[0]};

  always @(posedge clk) if (rom_rd) rom_data <= rom_addr[7:0];

  sprite_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .req(req), .req_addr(req_addr),
    .gnt(gnt), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy)
`ifdef SPRITE_ARB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  sprite_rom_arbiter #(.NUM_REQ(3), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) u_dut3 (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .req(req3), .req_addr({3{10'h155}}),
    .gnt(gnt3), .rom_rd(rom_rd3), .rom_addr(rom_addr3), .rom_data(8'h00),
    .rdata(rdata3), .rdata_valid(rdata_valid3), .busy(busy3)
`ifdef SPRITE_ARB_STATS_EN
    , .stall_cnt(stall3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  typedef struct {
    int            due;
    int            id;
    logic [AW-1:0] a;
  } entry_t;

  entry_t        sb[$];
  int            mptr = 0;
  logic [DW-1:0] mlast = '0;
  int            mstall = 0;

  always @(negedge clk) begin : monitor
    logic [NR-1:0] exp_rv;
    logic [NR-1:0] exp_gnt;
    logic          exp_rd;
    logic          exp_busy;
    logic [AW-1:0] exp_ra;
    logic [DW-1:0] exp_d;
    int            gi;
    int            lo;
    entry_t        e;
    if (!reset) begin
      sb.delete();
      mptr   = 0;
      mlast  = '0;
      mstall = 0;
    end
`ifdef SPRITE_ARB_STATS_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(mstall));
`endif
    exp_rv = '0; exp_rd = 1'b0; exp_busy = 1'b0; exp_ra = '0; exp_d = mlast;
    foreach (sb[i]) begin
      if (sb[i].due == cyc) begin
        exp_rv = NR'(1) << sb[i].id;
        exp_d  = sb[i].a[7:0];
      end
      if (sb[i].due == cyc + 2) begin
        exp_rd = 1'b1;
        exp_ra = sb[i].a;
      end
      if (sb[i].due == cyc + 1 || sb[i].due == cyc + 2) exp_busy = 1'b1;
    end
    chk("rdata_valid", 32'(rdata_valid), 32'(exp_rv));
    chk("rdata", 32'(rdata), 32'(exp_d));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("rom_rd", 32'(rom_rd), 32'(exp_rd));
    if (exp_rd) chk("rom_addr", 32'(rom_addr), 32'(exp_ra));
    mlast = exp_d;
    while (sb.size() > 0 && sb[0].due <= cyc) void'(sb.pop_front());

    exp_gnt = '0;
    gi = -1;
    for (int k = 0; k < NR; k++) begin
      if (gi < 0 && req[(mptr + k) % NR]) gi = (mptr + k) % NR;
    end
    lo = -1;
    for (int i = NR - 1; i >= 0; i--) if (req[i]) lo = i;
    if (reset && (|req) && (!fetch_en || gi != lo) && mstall < 16'hFFFF) mstall++;
    if (reset && fetch_en && gi >= 0) begin
      exp_gnt = NR'(1) << gi;
      e.due = cyc + 3;
      e.id  = gi;
      e.a   = addr[gi];
      sb.push_back(e);
      mptr = (gi + 1) % NR;
    end
    chk("gnt", 32'(gnt), 32'(exp_gnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NR-1:0] prev;
    reset = 1'b0; fetch_en = 1'b1; req = 2'b11; req3 = 3'b000;
    addr[0] = 10'h013; addr[1] = 10'h1C7;
    repeat (3) tick();
    reset = 1'b1;                               // first grant right after release
    tick();
    req = 2'b00;
    repeat (3) tick();

    req = 2'b10; addr[1] = 10'h2A5;             // single read
    tick();
    req = 2'b00;
    repeat (4) tick();

    req = 2'b11; addr[0] = 10'h013; addr[1] = 10'h1C7;
    repeat (6) tick();                          // contention
    req = 2'b00;
    repeat (4) tick();

    fetch_en = 1'b0; req = 2'b01; addr[0] = 10'h0E1;
    repeat (5) tick();                          // window closed
    fetch_en = 1'b1;
    tick();
    req = 2'b00;
    repeat (4) tick();

    req = 2'b01; addr[0] = 10'h33C;             // back-to-back same requester
    repeat (4) tick();
    req = 2'b00;
    repeat (4) tick();

    req3 = 3'b010;                              // 3-requester wrap
    #3 chk("gnt3_setup", 32'(gnt3), 32'h2);
    tick();
    req3 = 3'b101;
    #3 chk("gnt3_wrap0", 32'(gnt3), 32'h4);
    tick();
    #3 chk("gnt3_wrap1", 32'(gnt3), 32'h1);
    tick();
    #3 chk("gnt3_wrap2", 32'(gnt3), 32'h4);
    tick();
    req3 = 3'b000;
    repeat (3) tick();

    prev = '0;
    for (int n = 0; n < 60; n++) begin
      req = NR'($urandom_range(0, 3));
      fetch_en = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) if (!prev[i]) addr[i] = AW'($urandom());
      prev = req;
      tick();
    end
    req = 2'b00; fetch_en = 1'b1;
    repeat (5) tick();

    req = 2'b10; addr[1] = 10'h0AB;             // reset with a read in flight
    tick();
    req = 2'b00; reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
